// File: rtl/lgn_pkg.sv
// Shared constants and types for the LGN frame driver
// and the classifier's seven-segment encoder.
package lgn_pkg;

  localparam int FRAME_BYTES = 98;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111100;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Seven-segment pattern to digit index.
// Unknown patterns report index 4'hF with valid low.
module seg7_decode
  import lgn_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] index,
  output logic       valid
);

  always_comb begin
    index = 4'hF;
    valid = 1'b1;
    unique case (1'b1)
      (seg == SEG_0): index = 4'd0;
      (seg == SEG_1): index = 4'd1;
      (seg == SEG_2): index = 4'd2;
      (seg == SEG_3): index = 4'd3;
      (seg == SEG_4): index = 4'd4;
      (seg == SEG_5): index = 4'd5;
      (seg == SEG_6): index = 4'd6;
      (seg == SEG_7): index = 4'd7;
      (seg == SEG_8): index = 4'd8;
      (seg == SEG_9): index = 4'd9;
      default:        valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/lgn_frame_driver.sv
// Streams one binary frame into the LGN classifier,
// waits for it to settle and holds the decoded result.
module lgn_frame_driver #(
  parameter int FRAME_BYTES   = lgn_pkg::FRAME_BYTES,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        lgn_we,
  output logic [7:0]  lgn_data,
  input  logic [15:0] lgn_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_index,
  output logic [7:0]  res_value,
  output logic        res_error
);
  import lgn_pkg::*;

  localparam int CW = $clog2(FRAME_BYTES);

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] byte_cnt;
  logic [3:0]    settle_cnt;
  logic          accept;
  logic          last_byte;
  logic          settle_done;
  logic          capture;
  logic [3:0]    dec_index;
  logic          dec_valid;

  assign accept      = (state == S_LOAD) && src_valid;
  assign last_byte   = byte_cnt == CW'(FRAME_BYTES - 1);
  assign settle_done = settle_cnt == 4'd1;
  assign capture     = (state == S_SETTLE) && settle_done;

  seg7_decode u_dec (
    .seg   (lgn_out[6:0]),
    .index (dec_index),
    .valid (dec_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (accept && last_byte) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_done) state_nxt = S_HOLD;
      S_HOLD:   if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = state != S_IDLE;
    src_ready = state == S_LOAD;
    lgn_we    = accept;
    lgn_data  = (state == S_LOAD) ? src_data : 8'h00;
    res_valid = state == S_HOLD;
  end

  // The counter parks at zero after the last byte, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (accept && last_byte) begin
      settle_cnt <= 4'(SETTLE_CYCLES);
    end else if (state == S_SETTLE) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_index <= '0;
      res_value <= '0;
      res_error <= 1'b0;
    end else if (capture) begin
      res_index <= dec_valid ? dec_index : 4'hF;
      res_value <= lgn_out[15:8];
      res_error <= !dec_valid || !lgn_out[7];
    end
  end

endmodule

// File: tb/tb_lgn_frame_driver.sv
// Self-checking bench for lgn_frame_driver: vector table,
// random frames against a frame-level reference model.
module tb_lgn_frame_driver;

  localparam int FB = 98;
  localparam int SC = 4;
  localparam int NB = FB * 8;

  typedef struct {
    logic [15:0] lo;
    logic [3:0]  idx;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'h00;
  logic [15:0] lgn_out = 16'h0000;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        src_ready;
  logic        lgn_we;
  logic [7:0]  lgn_data;
  logic        res_valid;
  logic [3:0]  res_index;
  logic [7:0]  res_value;
  logic        res_error;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]    frame [FB];
  logic [NB-1:0] shadow;
  int            we_cnt;
  int            we_settle;
  logic          mon_clr = 1'b0;
  vec_t          vecs [7];

  always #5 clk = ~clk;

  lgn_frame_driver #(
    .FRAME_BYTES   (FB),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .lgn_we    (lgn_we),
    .lgn_data  (lgn_data),
    .lgn_out   (lgn_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_index (res_index),
    .res_value (res_value),
    .res_error (res_error)
  );

  // Shadow of the classifier's input shift register.
  always @(posedge clk) begin
    if (mon_clr) begin
      shadow    <= '0;
      we_cnt    <= 0;
      we_settle <= 0;
    end else begin
      if (lgn_we) begin
        shadow <= {shadow[NB-9:0], lgn_data};
        we_cnt <= we_cnt + 1;
      end
      if (lgn_we && !src_ready) we_settle <= we_settle + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference result: {error, index} from the digit table.
  function automatic logic [4:0] model_res(input logic [15:0] lo);
    logic [6:0] pats [10];
    pats = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
             7'b1100110, 7'b1101101, 7'b1111100, 7'b0000111,
             7'b1111111, 7'b1100111};
    for (int i = 0; i < 10; i++)
      if (lo[6:0] == pats[i]) return {!lo[7], 4'(i)};
    return {1'b1, 4'hF};
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " src_ready"}, src_ready, 0);
    chk({tag, " lgn_we"}, lgn_we, 0);
    chk({tag, " lgn_data"}, lgn_data, 0);
    chk({tag, " res_valid"}, res_valid, 0);
    chk({tag, " res_index"}, res_index, 0);
    chk({tag, " res_value"}, res_value, 0);
    chk({tag, " res_error"}, res_error, 0);
  endtask

  // mode 0: src_valid high, 1: toggling 1,0,1,0, 2: random stalls.
  task automatic run_frame(input int mode, input logic [15:0] lo,
                           input logic [3:0] e_idx, input logic e_err);
    int            stalls = 0;
    int            sent = 0;
    int            cyc = 0;
    bit            done = 0;
    logic          v;
    logic [NB-1:0] exp_bits = '0;
    logic [3:0]    h_idx;
    logic [7:0]    h_val;
    logic          h_err;
    for (int i = 0; i < FB; i++) exp_bits = {exp_bits[NB-9:0], frame[i]};
    @(negedge clk);
    mon_clr = 1'b1;
    lgn_out = lo;
    @(negedge clk);
    mon_clr = 1'b0;
    start = 1'b1;
    #1 chk("idle busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 2000) begin
      if (res_valid) begin
        done = 1;
      end else begin
        if (sent < FB) begin
          v = (mode == 0) ? 1'b1 :
              (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
          src_valid = v;
          src_data = v ? frame[sent] : 8'($urandom);
          #1;
          chk("load src_ready", src_ready, 1);
          chk("load lgn_we", lgn_we, v);
          chk("load lgn_data", lgn_data, src_data);
          chk("load busy", busy, 1);
          if (v) sent++;
          else stalls++;
        end else begin
          src_valid = 1'($urandom_range(0, 1));
          src_data = 8'($urandom);
          #1;
          chk("settle src_ready", src_ready, 0);
          chk("settle lgn_we", lgn_we, 0);
          chk("settle lgn_data", lgn_data, 0);
          chk("settle busy", busy, 1);
        end
        @(negedge clk);
        cyc++;
      end
    end
    src_valid = 1'b0;
    chk("result timeout", done, 1);
    chk("latency", cyc, 1 + FB + SC + stalls);
    chk("res_index", res_index, e_idx);
    chk("res_error", res_error, e_err);
    chk("res_value", res_value, lo[15:8]);
    chk("we pulses", we_cnt, FB);
    chk("we in settle", we_settle, 0);
    n_chk++;
    if (shadow !== exp_bits) begin
      n_fail++;
      $display("FAIL shadow frame: got %h want %h", shadow, exp_bits);
    end
    // Hold with res_ready low; start and lgn_out must not disturb it.
    h_idx = res_index;
    h_val = res_value;
    h_err = res_error;
    for (int k = 0; k < 10; k++) begin
      start = 1'(k % 2);
      lgn_out = 16'($urandom);
      @(negedge clk);
      chk("hold res_valid", res_valid, 1);
      chk("hold busy", busy, 1);
      chk("hold index", res_index, h_idx);
      chk("hold value", res_value, h_val);
      chk("hold error", res_error, h_err);
    end
    res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    chk("release res_valid", res_valid, 0);
    chk("release busy", busy, 0);
    @(negedge clk);
    chk("start during release ignored", busy, 0);
  endtask

  initial begin
    logic [4:0] m;
    vecs[0] = '{16'hC7E7, 4'd9, 1'b0};
    vecs[1] = '{16'h12BF, 4'd0, 1'b0};
    vecs[2] = '{16'hFFFF, 4'd8, 1'b0};
    vecs[3] = '{16'h33DB, 4'd2, 1'b0};
    vecs[4] = '{16'h0080, 4'hF, 1'b1};
    vecs[5] = '{16'h5A06, 4'd1, 1'b1};
    vecs[6] = '{16'h4CD5, 4'hF, 1'b1};

    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < FB; i++) frame[i] = 8'hFF;
    run_frame(0, 16'hC7E7, 4'd9, 1'b0);

    for (int i = 0; i < FB; i++) frame[i] = (i == 0) ? 8'h80 : 8'h00;
    run_frame(0, 16'hFFFF, 4'd8, 1'b0);
    chk("bit 783", shadow[NB-1], 1);
    chk("ones count", $countones(shadow), 1);

    for (int i = 0; i < FB; i++) frame[i] = 8'(i * 7 + 3);
    run_frame(1, 16'h33DB, 4'd2, 1'b0);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < FB; i++) frame[i] = 8'($urandom);
      run_frame(int'($urandom_range(0, 2)), vecs[t].lo,
                vecs[t].idx, vecs[t].err);
    end

    for (int t = 0; t < 5; t++) begin
      logic [15:0] lo;
      lo = 16'($urandom);
      if (t % 2 == 0) lo[7:0] = {1'($urandom), 7'b1101101};
      m = model_res(lo);
      for (int i = 0; i < FB; i++) frame[i] = 8'($urandom);
      run_frame(2, lo, m[3:0], m[4]);
    end

    // Reset in the middle of a frame.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      src_valid = 1'b1;
      src_data = 8'hA5;
      @(negedge clk);
    end
    chk("mid-frame busy", busy, 1);
    rst_n = 1'b0;
    #1 chk_reset_outs("mid reset");
    @(negedge clk);
    chk_reset_outs("mid reset held");
    src_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < FB; i++) frame[i] = 8'($urandom);
    m = model_res(16'h9E4F);
    run_frame(0, 16'h9E4F, m[3:0], m[4]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
